// File: rtl/ooo_pkg.sv
// Shared out-of-order core constants and the writeback request record.
// No logic; pure type/constant definitions.
// Imported by the writeback arbiter and the issue-select logic.
package ooo_pkg;

   localparam int FU_NUM    = 4;
   localparam int EPOCH_W   = 3;
   localparam int PHYS_REGS = 64;
   localparam int PHYS_W    = $clog2(PHYS_REGS);
   localparam int DW        = 32;

   typedef struct packed {
      logic [PHYS_W-1:0]  pd;
      logic [DW-1:0]      data;
      logic [EPOCH_W-1:0] epoch;
   } wb_req_t;

endpackage

// File: rtl/prf_wb_arbiter_rr.sv
// Round-robin picker: first asserted request at or above ptr, wrapping to 0.
// Purely combinational, zero latency.
// No backpressure; the caller decides when to advance ptr.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt_onehot,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   int idx;

   // Scan offsets from farthest to nearest so the nearest request to ptr wins.
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      any        = 1'b0;
      idx        = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N;
         if (req[idx]) begin
            gnt_idx = IW'(idx);
            any     = 1'b1;
         end
      end
      gnt_onehot[gnt_idx] = any;
   end

endmodule

// File: rtl/prf_wb_arbiter.sv
// Shares the single PRF writeback port among N_REQ FU result streams, squashing stale epochs.
// Latency: a result captured at edge t is presented on wb_* from cycle t+1.
// Backpressure: wb_ready low locks the grant (wb_* held) until fire or a flush kills it.
module prf_wb_arbiter
   import ooo_pkg::*;
#(
   parameter  int N_REQ     = FU_NUM,
   parameter  int PHYS_REGS = ooo_pkg::PHYS_REGS,
   parameter  int PHYS_W    = $clog2(PHYS_REGS),
   parameter  int DW        = ooo_pkg::DW,
   parameter  int EPOCH_W   = ooo_pkg::EPOCH_W,
   localparam int IW        = $clog2(N_REQ)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [N_REQ-1:0]                req_valid,
   output logic [N_REQ-1:0]                req_ready,
   input  logic [N_REQ-1:0][PHYS_W-1:0]    req_pd,
   input  logic [N_REQ-1:0][DW-1:0]        req_data,
   input  logic [N_REQ-1:0][EPOCH_W-1:0]   req_epoch,
   input  logic                            flush_valid,
   input  logic [EPOCH_W-1:0]              flush_epoch,
   output logic                            wb_valid,
   input  logic                            wb_ready,
   output logic [PHYS_W-1:0]               wb_pd,
   output logic [DW-1:0]                   wb_data,
   output logic [EPOCH_W-1:0]              wb_epoch,
   output logic [IW-1:0]                   wb_src
);

   typedef struct packed {
      logic [PHYS_W-1:0]  pd;
      logic [DW-1:0]      data;
      logic [EPOCH_W-1:0] epoch;
   } hold_t;

   hold_t              hold_q [N_REQ];
   logic [N_REQ-1:0]   hold_v;
   logic [N_REQ-1:0]   live;
   logic [N_REQ-1:0]   capture;
   logic [N_REQ-1:0]   arb_onehot;
   logic [N_REQ-1:0]   gnt_oh;
   logic [IW-1:0]      rr_ptr;
   logic [IW-1:0]      lock_idx;
   logic [IW-1:0]      arb_idx;
   logic [IW-1:0]      grant;
   logic               lock_v;
   logic               use_lock;
   logic               arb_any;
   logic               fire;
   logic [EPOCH_W-1:0] live_epoch;
   logic [EPOCH_W-1:0] eff_epoch;

   // An entry is live only if its epoch matches the epoch in force this cycle
   // (the incoming flush epoch wins); this also catches late FUs that missed a flush.
   always_comb begin
      eff_epoch = flush_valid ? flush_epoch : live_epoch;
      live      = '0;
      for (int i = 0; i < N_REQ; i++) begin
         live[i] = hold_v[i] & (hold_q[i].epoch == eff_epoch);
      end
   end

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req        (live),
      .ptr        (rr_ptr),
      .gnt_onehot (arb_onehot),
      .gnt_idx    (arb_idx),
      .any        (arb_any)
   );

   // A stalled grant keeps priority so wb_* stay stable until they fire.
   always_comb begin
      use_lock = lock_v & live[lock_idx];
      grant    = use_lock ? lock_idx : arb_idx;
      gnt_oh   = arb_onehot;
      if (use_lock) begin
         gnt_oh           = '0;
         gnt_oh[lock_idx] = 1'b1;
      end
   end

   assign wb_valid = arb_any;
   assign fire     = wb_valid & wb_ready;

   // A holder frees up when empty, when it fires, or when a flush kills it;
   // captures carrying an already-dead epoch are discarded on entry.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = ~hold_v[i] | (fire & gnt_oh[i]) | (flush_valid & ~live[i]);
         capture[i]   = req_valid[i] & req_ready[i]
                        & ~(flush_valid & (req_epoch[i] != flush_epoch));
      end
   end

   // Writeback bus shows the granted holder, zeros when nothing is live.
   always_comb begin
      wb_pd    = '0;
      wb_data  = '0;
      wb_epoch = '0;
      wb_src   = '0;
      if (wb_valid) begin
         wb_pd    = hold_q[grant].pd;
         wb_data  = hold_q[grant].data;
         wb_epoch = hold_q[grant].epoch;
         wb_src   = grant;
      end
   end

   // Holding-register payload; only meaningful while hold_v is set.
   always_ff @(posedge clk) begin
      for (int i = 0; i < N_REQ; i++) begin
         if (capture[i]) begin
            hold_q[i] <= '{pd: req_pd[i], data: req_data[i], epoch: req_epoch[i]};
         end
      end
   end

   // Occupancy: a ready holder is either refilled or emptied this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_v <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (capture[i]) begin
               hold_v[i] <= 1'b1;
            end else if (req_ready[i]) begin
               hold_v[i] <= 1'b0;
            end
         end
      end
   end

   // Round-robin pointer, stall lock and live epoch tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr     <= '0;
         lock_v     <= 1'b0;
         lock_idx   <= '0;
         live_epoch <= '0;
      end else begin
         if (flush_valid) begin
            live_epoch <= flush_epoch;
         end
         if (fire) begin
            lock_v <= 1'b0;
            rr_ptr <= (grant == IW'(N_REQ - 1)) ? '0 : grant + IW'(1);
         end else if (wb_valid) begin
            lock_v   <= 1'b1;
            lock_idx <= grant;
         end else begin
            lock_v <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prf_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a behavioural model.
// One process drives inputs, checks every cycle at negedge and steps the model at posedge.
// Terminates on its own after a fixed cycle count.
module tb_prf_wb_arbiter;

   localparam int N   = 4;
   localparam int PW  = 6;
   localparam int DWD = 32;
   localparam int EW  = 3;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic [N-1:0]           req_valid;
   logic [N-1:0]           req_ready;
   logic [N-1:0][PW-1:0]   req_pd;
   logic [N-1:0][DWD-1:0]  req_data;
   logic [N-1:0][EW-1:0]   req_epoch;
   logic                   flush_valid;
   logic [EW-1:0]          flush_epoch;
   logic                   wb_valid;
   logic                   wb_ready;
   logic [PW-1:0]          wb_pd;
   logic [DWD-1:0]         wb_data;
   logic [EW-1:0]          wb_epoch;
   logic [1:0]             wb_src;

   always #5 clk = ~clk;

   prf_wb_arbiter #(.N_REQ(N), .PHYS_REGS(64), .PHYS_W(PW), .DW(DWD), .EPOCH_W(EW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_pd(req_pd),
      .req_data(req_data), .req_epoch(req_epoch),
      .flush_valid(flush_valid), .flush_epoch(flush_epoch),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pd(wb_pd),
      .wb_data(wb_data), .wb_epoch(wb_epoch), .wb_src(wb_src)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Behavioural model: pending results per FU, the rotation start, a remembered
   // stalled presentation and the live epoch.
   bit            m_v   [N];
   logic [PW-1:0] m_pd  [N];
   logic [DWD-1:0] m_dat[N];
   logic [EW-1:0] m_ep  [N];
   int            m_ptr;
   bit            m_stall;
   int            m_sidx;
   logic [EW-1:0] m_lep;

   bit            e_live [N];
   int            e_gnt;
   bit            e_fire;
   logic [N-1:0]  e_rdy;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) m_v[i] = 1'b0;
      m_ptr = 0; m_stall = 1'b0; m_sidx = 0; m_lep = '0;
   endtask

   // Negedge: derive what the outputs must be and compare the whole bus.
   task automatic settle();
      logic [EW-1:0]  eff;
      logic [15:0]    got_ctl, exp_ctl;
      logic [DWD-1:0] exp_dat;
      @(negedge clk);
      eff = flush_valid ? flush_epoch : m_lep;
      for (int i = 0; i < N; i++) e_live[i] = m_v[i] && (m_ep[i] == eff);
      e_gnt = -1;
      if (m_stall && e_live[m_sidx]) e_gnt = m_sidx;
      else for (int k = 0; k < N; k++)
         if (e_gnt < 0 && e_live[(m_ptr + k) % N]) e_gnt = (m_ptr + k) % N;
      e_fire = (e_gnt >= 0) && wb_ready;
      for (int i = 0; i < N; i++)
         e_rdy[i] = !m_v[i] || (e_fire && e_gnt == i) || (flush_valid && !e_live[i]);
      got_ctl = {wb_valid, wb_src, wb_pd, wb_epoch, req_ready};
      if (e_gnt >= 0) begin
         exp_ctl = {1'b1, 2'(e_gnt), m_pd[e_gnt], m_ep[e_gnt], e_rdy};
         exp_dat = m_dat[e_gnt];
      end else begin
         exp_ctl = {1'b0, 2'd0, {PW{1'b0}}, {EW{1'b0}}, e_rdy};
         exp_dat = '0;
      end
      chk("cyc_ctl", 64'(got_ctl), 64'(exp_ctl));
      chk("cyc_data", 64'(wb_data), 64'(exp_dat));
   endtask

   // Posedge: apply captures, fires, flushes to the model.
   task automatic advance();
      @(posedge clk);
      if (!rst_n) model_reset();
      else begin
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && e_rdy[i]) begin
               if (flush_valid && req_epoch[i] != flush_epoch) m_v[i] = 1'b0;
               else begin
                  m_v[i] = 1'b1; m_pd[i] = req_pd[i]; m_dat[i] = req_data[i]; m_ep[i] = req_epoch[i];
               end
            end else if ((e_fire && e_gnt == i) || (flush_valid && !e_live[i])) m_v[i] = 1'b0;
         end
         if (e_fire) begin m_ptr = (e_gnt + 1) % N; m_stall = 1'b0; end
         else if (e_gnt >= 0) begin m_stall = 1'b1; m_sidx = e_gnt; end
         else m_stall = 1'b0;
         if (flush_valid) m_lep = flush_epoch;
      end
      #1;
   endtask

   task automatic idle_inputs();
      req_valid = '0; flush_valid = 1'b0; flush_epoch = '0; wb_ready = 1'b1;
   endtask

   task automatic set_req(input int i, input logic [PW-1:0] pd, input logic [DWD-1:0] d,
                          input logic [EW-1:0] ep);
      req_valid[i] = 1'b1; req_pd[i] = pd; req_data[i] = d; req_epoch[i] = ep;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; model_reset(); idle_inputs();
      settle(); advance(); settle(); advance();
      rst_n = 1'b1;
   endtask

   initial begin
      req_pd = '0; req_data = '0; req_epoch = '0;
      idle_inputs(); model_reset();

      // Reset state
      settle();
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'hF);
      chk("rst_wb_bus", 64'({wb_pd, wb_data, wb_epoch, wb_src}), 64'd0);
      advance(); settle(); advance();
      rst_n = 1'b1;

      // 1: single result, one-cycle latency, then idle
      idle_inputs(); set_req(0, 6'd5, 32'hA5, 3'd0);
      settle(); chk("t1_same_cycle", 64'(wb_valid), 64'd0); advance();
      idle_inputs();
      settle(); chk("t1_wb", 64'({wb_valid, wb_pd, wb_data, wb_src}), 64'({1'b1, 6'd5, 32'hA5, 2'd0}));
      advance();
      settle(); chk("t1_idle", 64'(wb_valid), 64'd0); advance();

      // 2: all FUs busy every cycle -> strict rotation 0,1,2,3,0,...
      do_reset();
      for (int c = 0; c < 9; c++) begin
         idle_inputs();
         for (int i = 0; i < N; i++) set_req(i, PW'(8 + i), $urandom, 3'd0);
         settle();
         if (c == 0) chk("t2_first", 64'(wb_valid), 64'd0);
         else begin
            chk("t2_grant", 64'({wb_valid, wb_src}), 64'({1'b1, 2'((c - 1) % 4)}));
            chk("t2_model", 64'(e_gnt), 64'((c - 1) % 4));
         end
         advance();
      end

      // 3: FU2 stalled three cycles while FU1 waits; grant must not move
      do_reset();
      idle_inputs(); wb_ready = 1'b0; set_req(2, 6'd22, 32'h2222, 3'd0);
      settle(); advance();
      idle_inputs(); wb_ready = 1'b0; set_req(1, 6'd11, 32'h1111, 3'd0);
      settle(); chk("t3_stall0", 64'({wb_valid, wb_src, wb_pd}), 64'({1'b1, 2'd2, 6'd22})); advance();
      idle_inputs(); wb_ready = 1'b0;
      settle(); chk("t3_stall1", 64'({wb_valid, wb_src, wb_pd}), 64'({1'b1, 2'd2, 6'd22})); advance();
      settle(); chk("t3_stall2", 64'({wb_valid, wb_src, wb_data}), 64'({1'b1, 2'd2, 32'h2222})); advance();
      wb_ready = 1'b1;
      settle(); chk("t3_fire2", 64'({wb_valid, wb_src}), 64'({1'b1, 2'd2})); advance();
      settle(); chk("t3_then1", 64'({wb_valid, wb_src, wb_data}), 64'({1'b1, 2'd1, 32'h1111})); advance();

      // 4: flush squashes FU1 (epoch 0), FU3 (epoch 1) is written
      do_reset();
      idle_inputs(); set_req(1, 6'd11, 32'h1, 3'd0); set_req(3, 6'd13, 32'h3, 3'd1);
      settle(); advance();
      idle_inputs(); flush_valid = 1'b1; flush_epoch = 3'd1;
      settle();
      chk("t4_fu3", 64'({wb_valid, wb_src, wb_pd}), 64'({1'b1, 2'd3, 6'd13}));
      chk("t4_rdy1", 64'(req_ready[1]), 64'd1);
      advance();
      idle_inputs();
      settle(); chk("t4_gone", 64'(wb_valid), 64'd0); advance();

      // 5: flush kills the locked entry; next live entry granted afterwards
      do_reset();
      idle_inputs(); wb_ready = 1'b0; set_req(0, 6'd7, 32'h70, 3'd0);
      settle(); advance();
      idle_inputs(); wb_ready = 1'b0;
      settle(); chk("t5_locked", 64'({wb_valid, wb_src, wb_pd}), 64'({1'b1, 2'd0, 6'd7})); advance();
      idle_inputs(); wb_ready = 1'b0; flush_valid = 1'b1; flush_epoch = 3'd1;
      set_req(2, 6'd9, 32'h90, 3'd1);
      settle();
      chk("t5_drop", 64'(wb_valid), 64'd0);
      chk("t5_rdy0", 64'(req_ready[0]), 64'd1);
      advance();
      idle_inputs();
      settle(); chk("t5_next", 64'({wb_valid, wb_src, wb_pd}), 64'({1'b1, 2'd2, 6'd9})); advance();
      settle(); chk("t5_empty", 64'(wb_valid), 64'd0); advance();

      // 6: async reset with three pending entries, rr pointer returns to 0
      do_reset();
      idle_inputs(); set_req(0, 6'd1, 32'h10, 3'd0);
      settle(); advance();
      idle_inputs();
      for (int i = 1; i < N; i++) set_req(i, PW'(i + 1), DWD'(i), 3'd0);
      settle(); chk("t6_fu0", 64'({wb_valid, wb_src}), 64'({1'b1, 2'd0})); advance();
      idle_inputs(); wb_ready = 1'b0;
      settle(); chk("t6_pend", 64'({wb_valid, wb_src}), 64'({1'b1, 2'd1}));
      #2 rst_n = 1'b0; model_reset();
      #1;
      chk("t6_async_wb", 64'(wb_valid), 64'd0);
      chk("t6_async_rdy", 64'(req_ready), 64'hF);
      advance();
      rst_n = 1'b1;
      idle_inputs(); set_req(0, 6'd2, 32'h20, 3'd0); set_req(3, 6'd4, 32'h40, 3'd0);
      settle(); chk("t6_rdy_after", 64'(req_ready), 64'hF); advance();
      idle_inputs();
      settle(); chk("t6_first0", 64'({wb_valid, wb_src, wb_pd}), 64'({1'b1, 2'd0, 6'd2})); advance();
      settle(); chk("t6_then3", 64'({wb_valid, wb_src, wb_pd}), 64'({1'b1, 2'd3, 6'd4})); advance();

      // Randomized traffic: valid, epochs, flushes and backpressure
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         idle_inputs();
         for (int i = 0; i < N; i++) begin
            logic [EW-1:0] ep;
            case ($urandom % 8)
               0:       ep = EW'(m_lep + 1);
               1:       ep = EW'(m_lep - 1);
               default: ep = m_lep;
            endcase
            if ($urandom % 3 != 0) set_req(i, PW'($urandom), $urandom, ep);
         end
         flush_valid = ($urandom % 12 == 0);
         flush_epoch = ($urandom % 2 == 0) ? EW'(m_lep + 1) : EW'($urandom);
         wb_ready    = ($urandom % 4 != 0);
         settle(); advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
